// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: walks instruction memory, drops instructions the R-type core cannot execute,
// and buffers the legal ones in a small FIFO behind a valid/ready handshake.
module mips_fetch_unit #(
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] end_addr,
    output logic              imem_rd_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    output logic [31:0]       instr_out,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [15:0]       illegal_count,
    output logic              busy,
    output logic              done
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] DEPTH = FIFO_DEPTH[PW:0];
    localparam logic [1:0] IDLE = 2'd0, FETCH = 2'd1, DRAIN = 2'd2, DONE = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W:0]   pc_q, pc_d;
    logic [ADDR_W-1:0] end_q, end_d;
    logic [15:0]       ill_q, ill_d;
    logic              inflight_q, inflight_d, stop_q, stop_d;
    logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d;
    logic [PW:0]       cnt_q, cnt_d;
    logic [31:0]       mem_q [FIFO_DEPTH];
    logic [31:0]       mem_d [FIFO_DEPTH];
    logic              issue, accept, ret, sentinel, legal, push, pop;

    always_comb begin
        // inflight counts toward occupancy so a returning word always has a free slot
        issue    = state_q == FETCH && pc_q <= {1'b0, end_q} && (cnt_q + (PW+1)'(inflight_q)) < DEPTH;
        accept   = start && (state_q == IDLE || state_q == DONE);
        ret      = inflight_q && !stop_q;
        sentinel = imem_data == 32'hFFFF_FFFF;
        legal    = imem_data[31:26] == 6'd0 &&
                   (imem_data[5:0] inside {6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h2B, 6'h00, 6'h02, 6'h03});
        push     = ret && !sentinel && legal;
        pop      = cnt_q != '0 && instr_ready;
        pc_d       = issue ? pc_q + 1'b1 : pc_q;
        end_d      = end_q;
        inflight_d = issue;
        stop_d     = stop_q || (ret && sentinel);
        ill_d      = (ret && !sentinel && !legal && ill_q != 16'hFFFF) ? ill_q + 16'd1 : ill_q;
        wr_d       = push ? wr_q + 1'b1 : wr_q;
        rd_d       = pop ? rd_q + 1'b1 : rd_q;
        cnt_d      = (push && !pop) ? cnt_q + 1'b1 : (!push && pop) ? cnt_q - 1'b1 : cnt_q;
        mem_d      = mem_q;
        if (push)
            mem_d[wr_q] = imem_data;
        state_d = state_q;
        if (state_q == FETCH && (stop_d || pc_d > {1'b0, end_q}))
            state_d = DRAIN;
        if (state_q == DRAIN && !inflight_q && cnt_q == '0)
            state_d = DONE;
        if (accept) begin
            state_d    = FETCH;
            pc_d       = '0;
            end_d      = end_addr;
            ill_d      = '0;
            wr_d       = '0;
            rd_d       = '0;
            cnt_d      = '0;
            stop_d     = 1'b0;
            inflight_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            end_q      <= '0;
            ill_q      <= '0;
            inflight_q <= 1'b0;
            stop_q     <= 1'b0;
            rd_q       <= '0;
            wr_q       <= '0;
            cnt_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            end_q      <= end_d;
            ill_q      <= ill_d;
            inflight_q <= inflight_d;
            stop_q     <= stop_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            cnt_q      <= cnt_d;
            mem_q      <= mem_d;
        end
    end

    assign imem_rd_en    = issue;
    assign imem_addr     = pc_q[ADDR_W-1:0];
    assign instr_out     = mem_q[rd_q];
    assign instr_valid   = cnt_q != '0;
    assign illegal_count = ill_q;
    assign busy          = state_q == FETCH || state_q == DRAIN;
    assign done          = state_q == DONE;
endmodule

// File: tb/tb_mips_fetch_unit.sv
// tb_mips_fetch_unit: table-driven program runs with an output scoreboard, plus stall, reset and saturation sequences.
module tb_mips_fetch_unit;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, instr_ready = 1'b0;
    logic [7:0]  end_addr = '0;
    logic        imem_rd_en, instr_valid, busy, done;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data = '0, instr_out;
    logic [15:0] illegal_count;
    logic        start2 = 1'b0;
    logic [16:0] end2 = 17'd69999;
    logic        rd2, valid2, busy2, done2;
    logic [16:0] addr2;
    logic [31:0] out2;
    logic [15:0] ill2;
    logic [31:0] mem [256];
    logic [31:0] exp_q [$];
    logic [7:0]  first_addr;
    int          applied = 0, miscomp = 0, rd_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk)
        if (imem_rd_en) imem_data <= mem[imem_addr];

    mips_fetch_unit #(.ADDR_W(8), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .end_addr(end_addr),
        .imem_rd_en(imem_rd_en), .imem_addr(imem_addr), .imem_data(imem_data),
        .instr_out(instr_out), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .illegal_count(illegal_count), .busy(busy), .done(done)
    );

    // wide-address instance fed a constant lw so every word is illegal
    mips_fetch_unit #(.ADDR_W(17), .FIFO_DEPTH(4)) dut_sat (
        .clk(clk), .rst(rst), .start(start2), .end_addr(end2),
        .imem_rd_en(rd2), .imem_addr(addr2), .imem_data(32'h8C08_0000),
        .instr_out(out2), .instr_valid(valid2), .instr_ready(1'b1),
        .illegal_count(ill2), .busy(busy2), .done(done2)
    );

    typedef struct {
        logic [31:0] prog [8];
        int          n;
        logic [7:0]  ea;
        logic [31:0] exp [8];
        int          nexp;
        logic [15:0] ill;
        bit          lat;
    } vec_t;

    vec_t vt [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        applied++;
        if (act !== req) begin
            miscomp++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        if (imem_rd_en) begin
            if (rd_cnt == 0) first_addr = imem_addr;
            rd_cnt++;
        end
        if (instr_valid && instr_ready) begin
            if (exp_q.size() == 0) chk("extra_out", instr_out, 32'hxxxx_xxxx);
            else chk("instr_out", instr_out, exp_q.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input logic [7:0] ea, input logic rdy);
        end_addr    = ea;
        instr_ready = rdy;
        rd_cnt      = 0;
        first_addr  = 8'hAA;
        start       = 1'b1;
        cycle();
        start       = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (!done && n < bound) begin
            cycle();
            n++;
        end
        chk("done_reached", {31'd0, done}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        for (int i = 0; i < 256; i++) mem[i] = 32'h012A_4025;
        for (int i = 0; i < v.n; i++) mem[i] = v.prog[i];
        for (int i = 0; i < v.nexp; i++) exp_q.push_back(v.exp[i]);
        kick(v.ea, 1'b1);
        if (v.lat) begin
            lat = 0;
            while (!instr_valid && lat < 20) begin
                cycle();
                lat++;
            end
            chk("latency", lat, 2);
        end
        wait_done(300);
        chk("leftover", exp_q.size(), 0);
        chk("illegal_count", {16'd0, illegal_count}, {16'd0, v.ill});
        chk("first_addr", {24'd0, first_addr}, 32'd0);
        cycle();
        chk("done_hold", {31'd0, done}, 32'd1);
        chk("busy_after", {31'd0, busy}, 32'd0);
    endtask

    task automatic load8();
        for (int i = 0; i < 256; i++) mem[i] = 32'h012A_4025;
        for (int i = 0; i < 8; i++) mem[i] = 32'h012A_4020 | (i << 16);
    endtask

    initial begin
        vt[0] = '{'{32'h012A4020, 32'h012A4022, 32'h00094080, 0, 0, 0, 0, 0}, 3, 8'd2,
                  '{32'h012A4020, 32'h012A4022, 32'h00094080, 0, 0, 0, 0, 0}, 3, 16'd0, 1'b1};
        vt[1] = '{'{32'h8C080000, 32'h012A4020, 32'h0000000C, 0, 0, 0, 0, 0}, 3, 8'd2,
                  '{32'h012A4020, 0, 0, 0, 0, 0, 0, 0}, 1, 16'd2, 1'b0};
        vt[2] = '{'{32'h012A4020, 32'hFFFFFFFF, 32'h012A4022, 0, 0, 0, 0, 0}, 3, 8'd2,
                  '{32'h012A4020, 0, 0, 0, 0, 0, 0, 0}, 1, 16'd0, 1'b1};
        vt[3] = '{'{32'h012A4021, 32'h012A4024, 32'h012A4025, 32'h012A402B,
                    32'h00000000, 32'h00094082, 32'h00094083, 32'h012A402A}, 8, 8'd7,
                  '{32'h012A4021, 32'h012A4024, 32'h012A4025, 32'h012A402B,
                    32'h00000000, 32'h00094082, 32'h00094083, 0}, 7, 16'd1, 1'b1};
        vt[4] = '{'{32'h012A4026, 32'h04000020, 32'h012A4023, 32'h012A4020, 0, 0, 0, 0}, 4, 8'd3,
                  '{32'h012A4020, 0, 0, 0, 0, 0, 0, 0}, 1, 16'd3, 1'b0};
        vt[5] = '{'{32'h012A4020, 32'h012A4022, 32'h012A4024, 32'h012A4021, 0, 0, 0, 0}, 4, 8'd1,
                  '{32'h012A4020, 32'h012A4022, 0, 0, 0, 0, 0, 0}, 2, 16'd0, 1'b1};
        vt[6] = '{'{32'hFFFFFFFF, 32'h012A4020, 0, 0, 0, 0, 0, 0}, 2, 8'd1,
                  '{0, 0, 0, 0, 0, 0, 0, 0}, 0, 16'd0, 1'b0};

        #12;
        chk("rst_rd_en", {31'd0, imem_rd_en}, 32'd0);
        chk("rst_addr", {24'd0, imem_addr}, 32'd0);
        chk("rst_instr_out", instr_out, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_illegal", {16'd0, illegal_count}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle();

        for (int v = 0; v < 7; v++) run_vec(vt[v]);

        // stall: FIFO fills to depth, reads stop, head holds
        load8();
        for (int i = 0; i < 8; i++) exp_q.push_back(32'h012A_4020 | (i << 16));
        begin
            logic stable = 1'b1;
            kick(8'd7, 1'b0);
            for (int c = 0; c < 10; c++) begin
                cycle();
                if (instr_valid && instr_out !== 32'h012A_4020) stable = 1'b0;
            end
            chk("stall_stable", {31'd0, stable}, 32'd1);
        end
        chk("stall_reads", rd_cnt, 4);
        chk("stall_valid", {31'd0, instr_valid}, 32'd1);
        chk("stall_head", instr_out, 32'h012A_4020);
        instr_ready = 1'b1;
        wait_done(100);
        chk("stall_leftover", exp_q.size(), 0);
        chk("stall_reads_total", rd_cnt, 8);

        // async reset mid-FETCH with two buffered and one read in flight
        load8();
        kick(8'd7, 1'b0);
        cycle();
        cycle();
        cycle();
        rst = 1'b1;
        #1;
        chk("mid_rst_rd_en", {31'd0, imem_rd_en}, 32'd0);
        chk("mid_rst_addr", {24'd0, imem_addr}, 32'd0);
        chk("mid_rst_out", instr_out, 32'd0);
        chk("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        cycle();
        rst = 1'b0;
        cycle();
        for (int i = 0; i < 8; i++) exp_q.push_back(32'h012A_4020 | (i << 16));
        kick(8'd7, 1'b1);
        wait_done(100);
        chk("refetch_addr", {24'd0, first_addr}, 32'd0);
        chk("refetch_leftover", exp_q.size(), 0);

        // full 256-word address space, PC must not wrap
        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'h0000_0020 | (i << 8);
            exp_q.push_back(32'h0000_0020 | (i << 8));
        end
        kick(8'hFF, 1'b1);
        wait_done(400);
        chk("full_leftover", exp_q.size(), 0);
        chk("full_reads", rd_cnt, 256);

        // 70000 illegal words saturate the counter
        start2 = 1'b1;
        cycle();
        start2 = 1'b0;
        begin
            int n = 0;
            while (!done2 && n < 72000) begin
                cycle();
                n++;
            end
        end
        chk("sat_done", {31'd0, done2}, 32'd1);
        chk("sat_count", {16'd0, ill2}, 32'h0000_FFFF);
        chk("sat_valid", {31'd0, valid2}, 32'd0);
        chk("sat_out", out2, 32'd0);
        chk("sat_rd_en", {31'd0, rd2}, 32'd0);
        chk("sat_busy", {31'd0, busy2}, 32'd0);
        chk("sat_addr", {15'd0, addr2}, 32'd70000);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscomp);
        $finish;
    end
endmodule
